// File: rtl/mem_port_arbiter.sv
// Purpose : shares one 32-bit memory port between instruction fetch (read-only) and load/store.
// Latency : request seen in IDLE -> ACCESS next cycle -> ack the cycle after; +1 per busy cycle.
// Backpressure: requesters hold req until ack; mem_busy_i stalls reads, stuck reads time out.
// Ports:
//   clk_i, rst_n_i                  clock, async active-low reset
//   if_req/addr -> if_ack/rdata/err fetch requester (read only)
//   ls_req/we/addr/wdata -> ls_ack/rdata/err  load/store requester
//   mem_en/wen/addr/wdata, mem_rdata_i, mem_busy_i   shared memory port
//   owner_ls_o                      debug: LS currently owns the port
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_ack_o,
  output logic [31:0] ls_rdata_o,
  output logic        ls_err_o,
  output logic        mem_en_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_busy_i,
  output logic        owner_ls_o
);

  localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIMIT);
  localparam logic [7:0] TIMEOUT_MAX = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic        owner_ls_q, owner_ls_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [7:0]  busy_cnt_q, busy_cnt_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_wen_q, mem_wen_d;
  logic        if_ack_q, if_ack_d, ls_ack_q, ls_ack_d;
  logic        if_err_q, if_err_d, ls_err_q, ls_err_d;
  logic [31:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;

  logic        grant_if, grant_ls;
  logic        xfer_done, xfer_err;
  logic [31:0] xfer_data;
  logic [7:0]  busy_inc;

  always_comb begin
    state_d      = state_q;
    owner_ls_d   = owner_ls_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    starve_cnt_d = starve_cnt_q;
    busy_cnt_d   = busy_cnt_q;
    mem_en_d     = 1'b0;
    mem_wen_d    = 1'b0;
    if_ack_d     = 1'b0;
    ls_ack_d     = 1'b0;
    if_err_d     = 1'b0;
    ls_err_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    grant_if     = 1'b0;
    grant_ls     = 1'b0;
    xfer_done    = 1'b0;
    xfer_err     = 1'b0;
    xfer_data    = 32'h0;
    busy_inc     = busy_cnt_q + 8'd1;

    unique case (state_q)
      IDLE: begin
        // LS has priority until IF has been passed over STARVE_LIMIT times in a row.
        grant_if = if_req_i && (!ls_req_i || (starve_cnt_q == STARVE_MAX));
        grant_ls = ls_req_i && !grant_if;
        if (grant_ls) begin
          owner_ls_d = 1'b1;
          we_d       = ls_we_i;
          addr_d     = ls_addr_i;
          wdata_d    = ls_wdata_i;
          state_d    = ACCESS;
          mem_en_d   = 1'b1;
          mem_wen_d  = ls_we_i;
          if (if_req_i && (starve_cnt_q != STARVE_MAX)) starve_cnt_d = starve_cnt_q + 4'd1;
        end else if (grant_if) begin
          owner_ls_d   = 1'b0;
          we_d         = 1'b0;
          addr_d       = if_addr_i;
          state_d      = ACCESS;
          mem_en_d     = 1'b1;
          starve_cnt_d = '0;
        end
      end
      ACCESS: begin
        mem_en_d  = 1'b1;
        mem_wen_d = we_q;
        // Stores are captured by the memory on the first ACCESS edge, busy or not.
        if (we_q) begin
          xfer_done = 1'b1;
        end else if (!mem_busy_i) begin
          xfer_done = 1'b1;
          xfer_data = mem_rdata_i;
        end else begin
          busy_cnt_d = busy_inc;
          if (busy_inc == TIMEOUT_MAX) begin
            xfer_done = 1'b1;
            xfer_err  = 1'b1;
          end
        end
        if (xfer_done) begin
          state_d   = RESP;
          mem_en_d  = 1'b0;
          mem_wen_d = 1'b0;
          if (owner_ls_q) begin
            ls_ack_d = 1'b1;
            ls_err_d = xfer_err;
            if (!we_q) ls_rdata_d = xfer_data;
          end else begin
            if_ack_d   = 1'b1;
            if_err_d   = xfer_err;
            if_rdata_d = xfer_data;
          end
        end
      end
      RESP: begin
        state_d    = IDLE;
        busy_cnt_d = '0;
        owner_ls_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // A withdrawn fetch request forgets any accumulated starvation.
    if (!if_req_i) starve_cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      owner_ls_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      starve_cnt_q <= '0;
      busy_cnt_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_wen_q    <= 1'b0;
      if_ack_q     <= 1'b0;
      ls_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      ls_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_ls_q   <= owner_ls_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      starve_cnt_q <= starve_cnt_d;
      busy_cnt_q   <= busy_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_wen_q    <= mem_wen_d;
      if_ack_q     <= if_ack_d;
      ls_ack_q     <= ls_ack_d;
      if_err_q     <= if_err_d;
      ls_err_q     <= ls_err_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_err_o    = if_err_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_ack_o    = ls_ack_q;
  assign ls_err_o    = ls_err_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_wen_o   = mem_wen_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign owner_ls_o  = owner_ls_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port (en/wen/addr/wdata/rdata/busy, word-addressed, 32-bit) between the instruction-fetch requester (IF, read-only) and the load/store requester (LS, read/write).
- Sits between the core's fetch/LSU stages and the memory model.
- Arbitrates with LS priority plus an IF anti-starvation limit.
- Holds the memory address stable through busy stalls, registers read data and times out stuck accesses.

Parameters:
- STARVE_LIMIT, 4, consecutive LS grants allowed while IF is pending before IF is forced to win (1..15).
- TIMEOUT, 15, maximum consecutive ACCESS cycles with mem_busy_i=1 before the access is aborted with error (1..255).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request; held until if_ack_o.
- if_addr_i  in  32  fetch byte address, word aligned.
- if_ack_o  out  1  one-cycle completion pulse.
- if_rdata_o  out  32  fetched word, valid while if_ack_o=1.
- if_err_o  out  1  qualifies if_ack_o: access timed out.
- ls_req_i  in  1  load/store request; held until ls_ack_o.
- ls_we_i  in  1  1=store, 0=load.
- ls_addr_i  in  32  byte address, word aligned.
- ls_wdata_i  in  32  store data.
- ls_ack_o  out  1  one-cycle completion pulse.
- ls_rdata_o  out  32  load data, valid while ls_ack_o=1 and ls_we_i=0.
- ls_err_o  out  1  qualifies ls_ack_o: timeout.
- mem_en_o  out  1  memory port enable.
- mem_wen_o  out  1  memory write enable.
- mem_addr_o  out  32  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data, combinational, valid when en=1, wen=0 and busy=0.
- mem_busy_i  in  1  memory stall indication.
- owner_ls_o  out  1  1 while LS owns the port (debug).

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs 0, including mem_addr_o. starve_cnt=0, busy_cnt=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, arbitration:
  - If both requests are asserted, LS wins unless starve_cnt==STARVE_LIMIT, in which case IF wins.
  - On a grant: latch owner, addr, we (IF always 0) and wdata into registers, then go to ACCESS.
  - No request: stay in IDLE.
- starve_cnt:
  - Increments on each LS grant while if_req_i=1, saturating at STARVE_LIMIT.
  - Clears on an IF grant or whenever if_req_i=0.
- ACCESS:
  - mem_en_o=1. mem_wen_o=latched we. mem_addr_o/mem_wdata_o=latched values, constant for the whole access.
  - Write completes in its first ACCESS cycle (memory captures on that edge) regardless of mem_busy_i.
  - Read completes in the first ACCESS cycle with mem_busy_i=0; mem_rdata_i is registered into the owner's rdata on that edge.
  - Either completion goes to RESP.
  - While mem_busy_i=1 on a read, busy_cnt increments. When busy_cnt reaches TIMEOUT, go to RESP with the error flag set and rdata=0.
- RESP:
  - Owner's ack_o=1 for exactly one cycle; err_o as latched. mem_en_o=0, mem_wen_o=0.
  - Then go to IDLE; busy_cnt clears.
- Outside ACCESS, mem_addr_o holds its last value so the memory sees no address change. mem_wdata_o also holds.
- rdata outputs:
  - if_rdata_o / ls_rdata_o hold their value after ack; only the owning side updates.
  - Non-owner ack and err are always 0.
- Latency and throughput:
  - Minimum latency: request seen in IDLE at cycle 0, ACCESS at cycle 1, ack at cycle 2.
  - Each busy cycle adds 1.
  - Peak throughput: 1 transaction per 3 cycles.
- Requester protocol:
  - Requesters must drop req in the ack cycle or present a new transaction; req asserted in the ack cycle is arbitrated in the following IDLE cycle.
  - Requests that change or are withdrawn before ack: undefined (bench asserts against this).
- Requests arriving while not in IDLE wait; no queuing beyond the held req.
- Reset mid-access: all state cleared immediately, no ack issued. A store in ACCESS may or may not have been written.

Test Plan:
- IF read only, addr 0x40, mem busy=0, mem word 0xDEADBEEF -> mem_en_o high cycle 1 with addr 0x40; if_ack_o cycle 2, if_rdata_o=0xDEADBEEF; if_err_o=0.
- LS store addr 0x4000 data 0x12345678 with busy=1 held -> write in first ACCESS cycle; ls_ack_o two cycles after req. A following LS load of 0x4000 returns 0x12345678.
- IF and LS both held continuously, STARVE_LIMIT=4 -> grant order LS,LS,LS,LS,IF,LS...; IF acked within 5 transactions.
- LS load with mem_busy_i=1 for 2 cycles -> mem_addr_o stable across the stall; ls_ack_o at cycle 4; data correct.
- LS load with mem_busy_i stuck high, TIMEOUT=15 -> ls_ack_o and ls_err_o together after 15 busy cycles; ls_rdata_o=0; FSM returns to IDLE and the next IF read succeeds.
- rst_n_i pulsed low during ACCESS -> all outputs 0 asynchronously; no ack; a new request after reset is served normally.
